// File: rtl/md_video_pkg.sv
// md_video_pkg: raster constants and the latched video mode bundle
// shared by the Mega Drive VDP timing path.
package md_video_pkg;

  typedef struct packed {
    logic h40;
    logic v30;
    logic pal;
    logic interlace;
  } md_vmode_t;

  localparam md_vmode_t VMODE_RST = '0;

  localparam logic [8:0] H32_TOTAL      = 9'd342;
  localparam logic [8:0] H40_TOTAL      = 9'd420;
  localparam logic [8:0] H32_ACTIVE     = 9'd256;
  localparam logic [8:0] H40_ACTIVE     = 9'd320;
  localparam logic [8:0] H32_HS_START   = 9'd280;
  localparam logic [8:0] H32_HS_END     = 9'd305;
  localparam logic [8:0] H40_HS_START   = 9'd340;
  localparam logic [8:0] H40_HS_END     = 9'd369;
  localparam logic [8:0] H40_SLOW_START = 9'd340;
  localparam logic [8:0] H40_SLOW_END   = 9'd369;

  localparam logic [8:0] V28_ACTIVE = 9'd224;
  localparam logic [8:0] V30_ACTIVE = 9'd240;
  localparam logic [8:0] VS_NTSC    = 9'd234;
  localparam logic [8:0] VS_PAL_V28 = 9'd258;
  localparam logic [8:0] VS_PAL_V30 = 9'd266;
  localparam logic [8:0] NTSC_LINES = 9'd262;
  localparam logic [8:0] PAL_LINES  = 9'd313;

  localparam logic [3:0] DIV_FAST = 4'd8;
  localparam logic [3:0] DIV_SLOW = 4'd10;

  function automatic logic [8:0] h_total(md_vmode_t m);
    return m.h40 ? H40_TOTAL : H32_TOTAL;
  endfunction

  function automatic logic [8:0] h_active(md_vmode_t m);
    return m.h40 ? H40_ACTIVE : H32_ACTIVE;
  endfunction

  function automatic logic [8:0] hs_start(md_vmode_t m);
    return m.h40 ? H40_HS_START : H32_HS_START;
  endfunction

  function automatic logic [8:0] hs_end(md_vmode_t m);
    return m.h40 ? H40_HS_END : H32_HS_END;
  endfunction

  function automatic logic [8:0] v_active(md_vmode_t m);
    return m.v30 ? V30_ACTIVE : V28_ACTIVE;
  endfunction

  function automatic logic [8:0] vs_start(md_vmode_t m);
    if (!m.pal) return VS_NTSC;
    return m.v30 ? VS_PAL_V30 : VS_PAL_V28;
  endfunction

  // Interlace: NTSC odd field is one line longer, PAL even field one shorter.
  function automatic logic [8:0] v_total(md_vmode_t m, logic field);
    logic [8:0] t;
    t = m.pal ? PAL_LINES : NTSC_LINES;
    if (m.interlace && !m.pal && field) t = t + 9'd1;
    if (m.interlace && m.pal && !field) t = t - 9'd1;
    return t;
  endfunction

endpackage

// File: rtl/md_pix_divider.sv
// md_pix_divider: master-clock to pixel-clock divider, /8 or /10,
// emitting a one-clk hclk1 pulse on the wrap cycle.
module md_pix_divider
  import md_video_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic slow_i,
  output logic hclk1_o
);

  logic [3:0] cnt_q, cnt_d;
  logic       wrap;

  always_comb begin
    wrap  = cnt_q == (slow_i ? DIV_SLOW - 4'd1 : DIV_FAST - 4'd1);
    cnt_d = wrap ? 4'd0 : cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign hclk1_o = wrap;

endmodule

// File: rtl/md_vdp_timing_gen.sv
// md_vdp_timing_gen: VDP raster timing (H32/H40, V28/V30, NTSC/PAL, interlace).
// Optional HV counter latch port enabled by MD_VDP_HV_LATCH_EN.
module md_vdp_timing_gen
  import md_video_pkg::*;
#(
  parameter int LINE_MCLK = 3420,
  parameter int VS_LINES  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       h40,
  input  logic       v30,
  input  logic       pal,
  input  logic       interlace_en,
`ifdef MD_VDP_HV_LATCH_EN
  input  logic       hl,
  output logic [15:0] hv_out,
`endif
  output logic       hclk1,
  output logic       de_h,
  output logic       de_v,
  output logic       hs_n,
  output logic       vs_n,
  output logic       intfield,
  output logic [8:0] hcnt,
  output logic [8:0] vcnt
);

  localparam logic [8:0] VS_W = 9'(VS_LINES);

  md_vmode_t  mode_q, mode_d, mode_in;
  logic       rel_q;
  logic [8:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic       field_q, field_d;
  logic       deh_q, deh_d, dev_q, dev_d;
  logic       hsn_q, hsn_d, vsn_q, vsn_d;
  logic       slow, tick, h_last, v_last, frame_wrap;

  md_pix_divider u_div (
    .clk    (clk),
    .reset  (reset),
    .slow_i (slow),
    .hclk1_o(tick)
  );

  always_comb begin
    mode_in    = {h40, v30, pal, interlace_en};
    h_last     = hcnt_q == h_total(mode_q) - 9'd1;
    v_last     = vcnt_q == v_total(mode_q, field_q) - 9'd1;
    frame_wrap = tick && h_last && v_last;
    slow       = !mode_q.h40 ||
                 (hcnt_q >= H40_SLOW_START && hcnt_q <= H40_SLOW_END);
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    mode_d  = mode_q;
    field_d = field_q;
    if (tick) begin
      hcnt_d = h_last ? 9'd0 : hcnt_q + 9'd1;
      if (h_last) vcnt_d = v_last ? 9'd0 : vcnt_q + 9'd1;
    end
    // Mode only moves on frame boundaries (and once as reset releases).
    if (frame_wrap || rel_q) mode_d = mode_in;
    if (frame_wrap) field_d = mode_in.interlace & ~field_q;
    deh_d = hcnt_q < h_active(mode_q);
    hsn_d = !(hcnt_q >= hs_start(mode_q) && hcnt_q <= hs_end(mode_q));
    dev_d = vcnt_q < v_active(mode_q);
    vsn_d = !(vcnt_q >= vs_start(mode_q) &&
              vcnt_q < vs_start(mode_q) + VS_W);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= VMODE_RST;
      rel_q   <= 1'b1;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      field_q <= 1'b0;
      deh_q   <= 1'b0;
      dev_q   <= 1'b0;
      hsn_q   <= 1'b1;
      vsn_q   <= 1'b1;
    end else begin
      mode_q  <= mode_d;
      rel_q   <= 1'b0;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      field_q <= field_d;
      deh_q   <= deh_d;
      dev_q   <= dev_d;
      hsn_q   <= hsn_d;
      vsn_q   <= vsn_d;
    end
  end

  logic [11:0] lclk_q;
  always_ff @(posedge clk) begin
    if (reset) lclk_q <= '0;
    else if (tick && h_last) begin
      assert (lclk_q == 12'(LINE_MCLK - 1));
      lclk_q <= '0;
    end else lclk_q <= lclk_q + 12'd1;
  end

`ifdef MD_VDP_HV_LATCH_EN
  logic        hl_q;
  logic [15:0] hv_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      hl_q <= 1'b0;
      hv_q <= '0;
    end else begin
      hl_q <= hl;
      if (hl && !hl_q)
        hv_q <= {mode_q.interlace ? {vcnt_q[7:1], vcnt_q[8]} : vcnt_q[7:0],
                 hcnt_q[8:1]};
    end
  end
  assign hv_out = hv_q;
`endif

  assign hclk1    = tick;
  assign de_h     = deh_q;
  assign de_v     = dev_q;
  assign hs_n     = hsn_q;
  assign vs_n     = vsn_q;
  assign intfield = field_q;
  assign hcnt     = hcnt_q;
  assign vcnt     = vcnt_q;

endmodule

// File: doc/md_vdp_timing_gen.md
Name: md_vdp_timing_gen

Overview:
- Raster timing generator for the Mega Drive VDP video path.
- Produces the pixel enable pulse, horizontal/vertical display-enable, active-low HSync/VSync and the interlace field flag, as the VDP presents them to the downstream video conditioning stage.
- Supports H32/H40, V28/V30, NTSC/PAL and interlace.
- Each line is exactly 3420 master clocks in every mode, so line rate is mode-independent.

Parameters:
- LINE_MCLK, 3420, master clocks per line; fixed by design, used by asserts only.
- VS_LINES, 3, VSync width in lines.

Ports:
- clk  in  1  master clock (53.69 MHz domain)
- reset  in  1  synchronous, active-high
- h40  in  1  1 = 320-pixel mode, 0 = 256-pixel mode
- v30  in  1  1 = 240 active lines, 0 = 224
- pal  in  1  1 = PAL line count
- interlace_en  in  1  alternate fields
- hclk1  out  1  one-clk pixel enable pulse
- de_h  out  1  horizontal active
- de_v  out  1  vertical active
- hs_n  out  1  HSync, active low
- vs_n  out  1  VSync, active low
- intfield  out  1  current field (0 even, 1 odd)
- hcnt  out  9  pixel counter
- vcnt  out  9  line counter

Behaviour:
- Reset values: counters 0, divider 0, hclk1=0, de_h=0, de_v=0, hs_n=1, vs_n=1, intfield=0, latched mode = H32/V28/NTSC/non-interlace.
- Pixel divider:
  - Counts 0..div-1. hclk1 pulses on the clk where the divider wraps; hcnt advances on the same clk.
  - H32: div=10 always.
  - H40: div=10 while hcnt is in 340..369, otherwise div=8.
  - Check: H32 342×10 = 3420; H40 390×8 + 30×10 = 3420.
- Horizontal:
  - H32: total 342, hcnt wraps 341→0. de_h=1 for hcnt 0..255. hs_n=0 for hcnt 280..305.
  - H40: total 420, wraps 419→0. de_h=1 for 0..319. hs_n=0 for 340..369.
- Vertical:
  - vcnt advances when hcnt wraps. de_v=1 for vcnt 0..223 (V28) or 0..239 (V30).
  - Total lines per frame: NTSC 262, PAL 313. With interlace, field 1 adds one line (NTSC 263) and PAL field 0 drops one (312).
  - vs_n=0 for VS_LINES lines starting at: NTSC 234; PAL V28 258; PAL V30 266. vs_n changes at the hcnt wrap.
- Field: intfield toggles at each frame wrap (vcnt→0) when latched interlace_en=1; forced to 0 otherwise.
- Mode latch:
  - h40, v30, pal and interlace_en are sampled only at the frame wrap (last line, hcnt wrap) and on reset release.
  - Mid-frame input changes have no effect until the next frame.
- Output timing: de_h, de_v, hs_n and vs_n are registered, one clk after the counter state that defines them. hcnt and vcnt are the live counters.
- Divider boundary: the switch between /8 and /10 is evaluated on the hcnt value after increment. The divider never produces a partial period.
- Reset mid-line: everything returns to reset values on the next clk. The first hclk1 after reset deasserts falls 10 clks later (H32 default).

Optional Feature:
- Macro: MD_VDP_HV_LATCH_EN.
- With the macro:
  - Adds input hl (external HV latch request) and output hv_out[15:0].
  - On the rising edge of hl, hv_out is loaded with {vcnt[7:0], hcnt[8:1]}. With interlace enabled, bit 8 of vcnt replaces bit 0.
  - hv_out holds until the next hl edge. Reset value 0.
- Without the macro: the ports do not exist and no latch logic is present.

Decomposition:
- Package md_video_pkg holds:
  - per-mode constants: H totals, active widths, HS start/end, H40 /10 window, V active, VS start per mode/standard, line totals;
  - typedef md_vmode_t {h40, v30, pal, interlace}.
- One sub-module, md_pix_divider: divider counter plus /8 or /10 select input and hclk1 output.

Test Plan:
- Reset, H32 NTSC, run 2 frames → hclk1 period 10 clks; 342 hclk1 per hs_n falling edge; de_h high 256 pixels; 262 lines between vs_n falling edges; vs_n low 3 lines starting line 234.
- H40 PAL V30 → 3420 clks between hs_n falls; hs_n low 30 pixels, each 10 clks; de_h 320 pixels; de_v 240 lines; 313 lines/frame; vs_n falls at line 266.
- Toggle h40 at line 100 → line timing unchanged until vcnt wraps; new mode from line 0 of next frame; no line ≠ 3420 clks.
- NTSC interlace_en=1 → intfield alternates each frame; frame lengths alternate 262/263 lines.
- Assert reset mid-line (hcnt=150) → next clk all outputs at reset values; first hclk1 10 clks after release.
- With MD_VDP_HV_LATCH_EN, pulse hl at vcnt=0x50, hcnt=0x0A0 → hv_out=0x5050 and held across further lines.
